// File: rtl/ifetcher.sv
// Instruction fetch stage: issues pc to the I-cache, predicts the next pc from the
// returned word, and hands instructions to decode with a one-entry stall buffer.
module ifetcher (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        IC_addr_sgn,
    output logic [31:0] IC_addr,
    input  logic        IC_val_sgn,
    input  logic [31:0] IC_val,
    input  logic        ID_stall,
    output logic        ID_inst_sgn,
    output logic [31:0] ID_inst,
    output logic [31:0] ID_pc,
    output logic        ID_pred_jump,
    input  logic        ROB_clr,
    input  logic [31:0] ROB_pc
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    logic [31:0] hold_npc;
    logic        hold_pred;

    logic [31:0] j_imm;
    logic [31:0] b_imm;
    logic [31:0] npc;
    logic        pred;

    // Static prediction: JAL always taken, conditional branches taken only when backward.
    always_comb begin
        j_imm = {{11{IC_val[31]}}, IC_val[31], IC_val[19:12], IC_val[20], IC_val[30:21], 1'b0};
        b_imm = {{19{IC_val[31]}}, IC_val[31], IC_val[7], IC_val[30:25], IC_val[11:8], 1'b0};
        npc   = pc + 32'd4;
        pred  = 1'b0;
        if (IC_val[6:0] == OP_JAL) begin
            npc  = pc + j_imm;
            pred = 1'b1;
        end else if (IC_val[6:0] == OP_BRANCH && IC_val[31]) begin
            npc  = pc + b_imm;
            pred = 1'b1;
        end
    end

    assign IC_addr_sgn = (state == S_FETCH);
    assign IC_addr     = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            pc           <= 32'd0;
            ID_inst_sgn  <= 1'b0;
            ID_inst      <= 32'd0;
            ID_pc        <= 32'd0;
            ID_pred_jump <= 1'b0;
            hold_inst    <= 32'd0;
            hold_pc      <= 32'd0;
            hold_npc     <= 32'd0;
            hold_pred    <= 1'b0;
        end else if (rdy) begin
            ID_inst_sgn <= 1'b0;
            if (ROB_clr) begin
                // Flush wins over any response or held word arriving this cycle.
                state     <= S_DROP;
                pc        <= ROB_pc;
                hold_inst <= 32'd0;
                hold_pc   <= 32'd0;
                hold_npc  <= 32'd0;
                hold_pred <= 1'b0;
            end else begin
                case (state)
                    S_FETCH: begin
                        if (IC_val_sgn && !ID_stall) begin
                            ID_inst_sgn  <= 1'b1;
                            ID_inst      <= IC_val;
                            ID_pc        <= pc;
                            ID_pred_jump <= pred;
                            pc           <= npc;
                        end else if (IC_val_sgn) begin
                            state     <= S_HOLD;
                            hold_inst <= IC_val;
                            hold_pc   <= pc;
                            hold_npc  <= npc;
                            hold_pred <= pred;
                        end
                    end
                    S_HOLD: begin
                        if (!ID_stall) begin
                            state        <= S_FETCH;
                            ID_inst_sgn  <= 1'b1;
                            ID_inst      <= hold_inst;
                            ID_pc        <= hold_pc;
                            ID_pred_jump <= hold_pred;
                            pc           <= hold_npc;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ifetcher.sv
// Directed and randomized checks of ifetcher against a queue-based reference model.
module tb_ifetcher;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        IC_addr_sgn;
    logic [31:0] IC_addr;
    logic        IC_val_sgn = 1'b0;
    logic [31:0] IC_val = 32'd0;
    logic        ID_stall = 1'b0;
    logic        ID_inst_sgn;
    logic [31:0] ID_inst;
    logic [31:0] ID_pc;
    logic        ID_pred_jump;
    logic        ROB_clr = 1'b0;
    logic [31:0] ROB_pc = 32'd0;

    int total = 0;
    int bad   = 0;

    ifetcher dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .IC_addr_sgn(IC_addr_sgn), .IC_addr(IC_addr),
        .IC_val_sgn(IC_val_sgn), .IC_val(IC_val),
        .ID_stall(ID_stall),
        .ID_inst_sgn(ID_inst_sgn), .ID_inst(ID_inst), .ID_pc(ID_pc), .ID_pred_jump(ID_pred_jump),
        .ROB_clr(ROB_clr), .ROB_pc(ROB_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetched_t;

    // Reference model: a held-instruction queue, a drop flag and the outputs last presented.
    logic [31:0] m_pc;
    bit          m_drop;
    fetched_t    m_held[$];
    bit          m_vld;
    logic [31:0] m_inst, m_ipc;
    bit          m_pred;

    function automatic logic [32:0] ref_next(input logic [31:0] w, input logic [31:0] pc);
        int off;
        logic p;
        if (w[6:0] == 7'h6F) begin
            off = (w[31] ? -1048576 : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11)
                + (int'(w[30:21]) << 1);
            p = 1'b1;
        end else if (w[6:0] == 7'h63 && w[31]) begin
            off = -4096 + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) + (int'(w[11:8]) << 1);
            p = 1'b1;
        end else begin
            off = 4;
            p = 1'b0;
        end
        return {p, pc + 32'(off)};
    endfunction

    function automatic bit m_requesting();
        return !m_drop && m_held.size() == 0;
    endfunction

    task automatic m_deliver(input fetched_t f);
        logic [32:0] n;
        n      = ref_next(f.word, f.pc);
        m_vld  = 1'b1;
        m_inst = f.word;
        m_ipc  = f.pc;
        m_pred = n[32];
        m_pc   = n[31:0];
    endtask

    task automatic m_step(input bit r, input bit en, input bit v, input logic [31:0] w,
                          input bit st, input bit c, input logic [31:0] rp);
        fetched_t f;
        if (r) begin
            m_pc = 32'd0; m_drop = 0; m_held.delete(); m_vld = 0;
        end else if (en) begin
            m_vld = 0;
            if (c) begin
                m_pc = rp; m_drop = 1; m_held.delete();
            end else if (m_drop) begin
                m_drop = 0;
            end else if (m_held.size() != 0) begin
                if (!st) m_deliver(m_held.pop_front());
            end else if (v) begin
                f.word = w; f.pc = m_pc;
                if (st) m_held.push_back(f);
                else    m_deliver(f);
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return at the next falling edge.
    task automatic step(input logic v, input logic [31:0] w, input logic st,
                        input logic c, input logic [31:0] rp);
        IC_val_sgn = v; IC_val = w; ID_stall = st; ROB_clr = c; ROB_pc = rp;
        @(posedge clk);
        @(negedge clk);
        IC_val_sgn = 1'b0; ROB_clr = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        step(1'b0, 32'd0, 1'b0, 1'b1, target);
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 32'h00000013, 1'b0, 1'b1, 32'h100);
        total++; if (ID_inst_sgn !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", ID_inst_sgn); end
        total++; if (ID_inst !== 32'd0) begin bad++; $display("FAIL rst_inst got=%h exp=0", ID_inst); end
        total++; if (ID_pc !== 32'd0 || ID_pred_jump !== 1'b0) begin bad++; $display("FAIL rst_pc_pred got=%h/%b exp=0/0", ID_pc, ID_pred_jump); end
        total++; if (IC_addr !== 32'd0) begin bad++; $display("FAIL rst_addr got=%h exp=0", IC_addr); end
        rst = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        total++; if (IC_addr_sgn !== 1'b1 || IC_addr !== 32'd0) begin bad++; $display("FAIL rst_release got=%b/%h exp=1/0", IC_addr_sgn, IC_addr); end
    endtask

    task automatic test_sequential();
        step(1'b1, 32'h00000013, 1'b0, 1'b0, 32'd0);
        total++; if (ID_inst_sgn !== 1'b1 || ID_inst !== 32'h13 || ID_pc !== 32'd0) begin bad++; $display("FAIL seq_deliver got=%b/%h/%h exp=1/13/0", ID_inst_sgn, ID_inst, ID_pc); end
        total++; if (ID_pred_jump !== 1'b0 || IC_addr !== 32'h4 || IC_addr_sgn !== 1'b1) begin bad++; $display("FAIL seq_next got=%b/%h/%b exp=0/4/1", ID_pred_jump, IC_addr, IC_addr_sgn); end
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        total++; if (ID_inst_sgn !== 1'b0) begin bad++; $display("FAIL seq_pulse got=%b exp=0", ID_inst_sgn); end
    endtask

    task automatic test_jal();
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h10);
        total++; if (IC_addr_sgn !== 1'b0 || IC_addr !== 32'h10) begin bad++; $display("FAIL drop_state got=%b/%h exp=0/10", IC_addr_sgn, IC_addr); end
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 32'h0100006F, 1'b0, 1'b0, 32'd0);
        total++; if (ID_inst_sgn !== 1'b1 || ID_pc !== 32'h10 || ID_pred_jump !== 1'b1) begin bad++; $display("FAIL jal_deliver got=%b/%h/%b exp=1/10/1", ID_inst_sgn, ID_pc, ID_pred_jump); end
        total++; if (IC_addr !== 32'h20) begin bad++; $display("FAIL jal_target got=%h exp=20", IC_addr); end
    endtask

    task automatic test_branch();
        redirect(32'h40);
        step(1'b1, 32'hFE000EE3, 1'b0, 1'b0, 32'd0);
        total++; if (ID_pred_jump !== 1'b1 || IC_addr !== 32'h3C) begin bad++; $display("FAIL bwd_branch got=%b/%h exp=1/3c", ID_pred_jump, IC_addr); end
        redirect(32'h40);
        step(1'b1, 32'h00000463, 1'b0, 1'b0, 32'd0);
        total++; if (ID_pred_jump !== 1'b0 || IC_addr !== 32'h44) begin bad++; $display("FAIL fwd_branch got=%b/%h exp=0/44", ID_pred_jump, IC_addr); end
    endtask

    task automatic test_stall();
        int seen = 0;
        step(1'b1, 32'h00000013, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            total++; if (IC_addr_sgn !== 1'b0 || ID_inst_sgn !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got=%b/%b exp=0/0", i, IC_addr_sgn, ID_inst_sgn); end
            step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        end
        total++; if (IC_addr_sgn !== 1'b0 || ID_inst_sgn !== 1'b0) begin bad++; $display("FAIL stall_hold2 got=%b/%b exp=0/0", IC_addr_sgn, ID_inst_sgn); end
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        total++; if (ID_inst_sgn !== 1'b1 || ID_pc !== 32'h44 || ID_inst !== 32'h13) begin bad++; $display("FAIL stall_release got=%b/%h/%h exp=1/44/13", ID_inst_sgn, ID_pc, ID_inst); end
        total++; if (IC_addr !== 32'h48 || IC_addr_sgn !== 1'b1) begin bad++; $display("FAIL stall_next got=%h/%b exp=48/1", IC_addr, IC_addr_sgn); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            if (ID_inst_sgn) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL stall_single got=%0d extra exp=0", seen); end
    endtask

    task automatic test_flush_hold();
        int seen = 0;
        step(1'b1, 32'h00000013, 1'b1, 1'b0, 32'd0);
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'h100);
        total++; if (IC_addr_sgn !== 1'b0 || ID_inst_sgn !== 1'b0 || IC_addr !== 32'h100) begin bad++; $display("FAIL flush_drop got=%b/%b/%h exp=0/0/100", IC_addr_sgn, ID_inst_sgn, IC_addr); end
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        total++; if (IC_addr_sgn !== 1'b1 || IC_addr !== 32'h100 || ID_inst_sgn !== 1'b0) begin bad++; $display("FAIL flush_refetch got=%b/%h/%b exp=1/100/0", IC_addr_sgn, IC_addr, ID_inst_sgn); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            if (ID_inst_sgn) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_no_deliver got=%0d exp=0", seen); end
    endtask

    task automatic test_rdy();
        rdy = 1'b0;
        step(1'b1, 32'h00000013, 1'b0, 1'b1, 32'h200);
        total++; if (IC_addr_sgn !== 1'b1 || IC_addr !== 32'h100 || ID_inst_sgn !== 1'b0) begin bad++; $display("FAIL rdy_low got=%b/%h/%b exp=1/100/0", IC_addr_sgn, IC_addr, ID_inst_sgn); end
        rdy = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        total++; if (IC_addr_sgn !== 1'b1 || IC_addr !== 32'h100 || ID_inst_sgn !== 1'b0) begin bad++; $display("FAIL rdy_lost got=%b/%h/%b exp=1/100/0", IC_addr_sgn, IC_addr, ID_inst_sgn); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        step(1'b1, 32'h00000013, 1'b1, 1'b0, 32'd0);
        rst = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        total++; if (IC_addr_sgn !== 1'b1 || IC_addr !== 32'd0 || ID_inst_sgn !== 1'b0) begin bad++; $display("FAIL rst_hold got=%b/%h/%b exp=1/0/0", IC_addr_sgn, IC_addr, ID_inst_sgn); end
        step(1'b0, 32'd0, 1'b0, 1'b1, 32'h80);
        rst = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        total++; if (IC_addr_sgn !== 1'b1 || IC_addr !== 32'd0) begin bad++; $display("FAIL rst_drop got=%b/%h exp=1/0", IC_addr_sgn, IC_addr); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            if (ID_inst_sgn) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_no_deliver got=%0d exp=0", seen); end
    endtask

    task automatic test_random();
        logic        v, st, c, r, en;
        logic [31:0] w, rp;
        int          errs = 0;
        rst = 1'b1;
        step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        m_step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 19) == 0);
            st = ($urandom_range(0, 9) < 3);
            rp = {$urandom_range(0, 32'hFFFF), 2'b00};
            w  = $urandom;
            case ($urandom_range(0, 3))
                0:       w[6:0] = 7'h6F;
                1:       w[6:0] = 7'h63;
                2:       w[6:0] = 7'h67;
                default: w[6:0] = 7'h13;
            endcase
            v = (m_requesting() || c) && ($urandom_range(0, 9) < 4);
            rst = r; rdy = en;
            step(v, w, st, c, rp);
            m_step(r, en, v, w, st, c, rp);
            total++;
            if (IC_addr_sgn !== m_requesting() || IC_addr !== m_pc || ID_inst_sgn !== m_vld) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_ctrl cyc=%0d got=%b/%h/%b exp=%b/%h/%b", n,
                    IC_addr_sgn, IC_addr, ID_inst_sgn, m_requesting(), m_pc, m_vld);
            end else if (m_vld) begin
                total++;
                if (ID_inst !== m_inst || ID_pc !== m_ipc || ID_pred_jump !== m_pred) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rand_data cyc=%0d got=%h/%h/%b exp=%h/%h/%b", n,
                        ID_inst, ID_pc, ID_pred_jump, m_inst, m_ipc, m_pred);
                end
            end
        end
        rst = 1'b0; rdy = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_jal();
        test_branch();
        test_stall();
        test_flush_hold();
        test_rdy();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
